// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-port data memory with a fixed-latency valid/ready request/response
//   handshake for an RV32I load/store unit. One request is in flight at a time.
//   A request is accepted in IDLE. The FSM then spends LATENCY cycles in WAIT,
//   or goes straight to RESP when LATENCY=0. The memory access happens on the
//   edge into RESP. The response is held in RESP until rsp_ready is seen.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words of storage
//   LATENCY     : wait cycles between accept and response (0..15)
//
// Ports
//   clk, rst_n             : clock, synchronous active-low reset
//   req_valid / req_ready  : request handshake (req_ready only in IDLE)
//   req_we                 : 1 = store, 0 = load
//   req_addr               : byte address
//   req_funct3             : RV32I size code (b, h, w, bu, hu)
//   req_wdata              : right-aligned store data
//   rsp_valid / rsp_ready  : response handshake
//   rsp_rdata              : extended load data; 0 for stores and errors
//   rsp_err                : misaligned, out of range or illegal funct3
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW         = $clog2(DEPTH_WORDS);
    localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  LAT_LOAD   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam bit          LAT_ZERO   = (LATENCY == 0);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        accept;
    logic        access;
    logic        a_we;
    logic [31:0] a_addr;
    logic [2:0]  a_funct3;
    logic [31:0] a_wdata;
    logic        a_err;
    logic        illegal, misaligned, out_of_range;
    logic [AW-1:0] word_idx;
    logic [31:0] rd_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] acc_rdata;
    logic [3:0]  be;
    logic [31:0] wd_rep;
    logic        mem_we;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign accept    = req_valid && (state_q == IDLE);

    // The access edge is WAIT with count 0, or the accept edge itself when
    // LATENCY=0. In the latter case the operands come straight from req_*,
    // which only feeds registers, never the response outputs directly.
    assign access = ((state_q == WAIT) && (cnt_q == 4'd0)) ||
                    (LAT_ZERO && accept);

    always_comb begin
        a_we     = we_q;
        a_addr   = addr_q;
        a_funct3 = funct3_q;
        a_wdata  = wdata_q;
        if (state_q == IDLE) begin
            a_we     = req_we;
            a_addr   = req_addr;
            a_funct3 = req_funct3;
            a_wdata  = req_wdata;
        end
    end

    // Request legality
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (a_funct3)
            3'b000:  misaligned = 1'b0;
            3'b001:  misaligned = a_addr[0];
            3'b010:  misaligned = (a_addr[1:0] != 2'b00);
            3'b100:  illegal    = a_we;
            3'b101:  begin
                illegal    = a_we;
                misaligned = a_addr[0];
            end
            default: illegal    = 1'b1;
        endcase
        out_of_range = ({1'b0, a_addr} >= BYTE_LIMIT);
        a_err        = illegal || misaligned || out_of_range;
    end

    assign word_idx = a_addr[AW+1:2];
    assign rd_word  = mem_q[word_idx];
    assign ld_byte  = rd_word[{a_addr[1:0], 3'b000} +: 8];
    assign ld_half  = a_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (a_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = rd_word;
        endcase
        acc_rdata = (a_err || a_we) ? 32'd0 : ld_data;
    end

    // Store lane enables and lane-replicated write data
    always_comb begin
        case (a_funct3[1:0])
            2'b00: begin
                be     = 4'b0001 << a_addr[1:0];
                wd_rep = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                be     = a_addr[1] ? 4'b1100 : 4'b0011;
                wd_rep = {2{a_wdata[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wd_rep = a_wdata;
            end
        endcase
    end

    // Gated by rst_n so a reset landing on the access edge aborts the store.
    assign mem_we = access && a_we && !a_err && rst_n;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d     = req_we;
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    wdata_d  = req_wdata;
                    if (LAT_ZERO) begin
                        state_d = RESP;
                        rdata_d = acc_rdata;
                        err_d   = a_err;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    rdata_d = acc_rdata;
                    err_d   = a_err;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            funct3_q <= 3'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[word_idx][8*i +: 8] <= wd_rep[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;

    // Instance A: LATENCY=2
    logic        a_req_valid, a_req_ready, a_req_we;
    logic [31:0] a_req_addr, a_req_wdata;
    logic [2:0]  a_req_funct3;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_rsp_rdata;

    // Instance B: LATENCY=0
    logic        b_req_valid, b_req_ready, b_req_we;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [2:0]  b_req_funct3;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010;
    localparam logic [2:0] F_BU = 3'b100, F_HU = 3'b101;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (a_req_valid),
        .req_ready  (a_req_ready),
        .req_we     (a_req_we),
        .req_addr   (a_req_addr),
        .req_funct3 (a_req_funct3),
        .req_wdata  (a_req_wdata),
        .rsp_valid  (a_rsp_valid),
        .rsp_ready  (a_rsp_ready),
        .rsp_rdata  (a_rsp_rdata),
        .rsp_err    (a_rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_we     (b_req_we),
        .req_addr   (b_req_addr),
        .req_funct3 (b_req_funct3),
        .req_wdata  (b_req_wdata),
        .rsp_valid  (b_rsp_valid),
        .rsp_ready  (b_rsp_ready),
        .rsp_rdata  (b_rsp_rdata),
        .rsp_err    (b_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full transaction with rsp_ready=1. cyc counts cycles from the
    // accept cycle (cycle 0) to the first cycle with rsp_valid high.
    task automatic xact(input bit sel, input logic we, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int cyc);
        logic v;
        @(negedge clk);
        if (sel) begin
            b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr;
            b_req_funct3 = f3; b_req_wdata = wd; b_rsp_ready = 1'b1;
        end else begin
            a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr;
            a_req_funct3 = f3; a_req_wdata = wd; a_rsp_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        cyc = 1;
        v = sel ? b_rsp_valid : a_rsp_valid;
        while (v !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            v = sel ? b_rsp_valid : a_rsp_valid;
        end
        rd  = sel ? b_rsp_rdata : a_rsp_rdata;
        err = sel ? b_rsp_err : a_rsp_err;
        if (v !== 1'b1) begin
            n_checks++;
            $display("FAIL xact_timeout addr=%h: rsp_valid got %b want 1", addr, v);
        end
        @(posedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if (a_req_ready !== 1'b1) $display("FAIL rst_a_req_ready: got %b want 1", a_req_ready); else n_pass++;
        n_checks++; if (a_rsp_valid !== 1'b0) $display("FAIL rst_a_rsp_valid: got %b want 0", a_rsp_valid); else n_pass++;
        n_checks++; if (a_rsp_rdata !== 32'd0) $display("FAIL rst_a_rdata: got %h want 0", a_rsp_rdata); else n_pass++;
        n_checks++; if (a_rsp_err !== 1'b0) $display("FAIL rst_a_err: got %b want 0", a_rsp_err); else n_pass++;
        n_checks++; if (b_req_ready !== 1'b1) $display("FAIL rst_b_req_ready: got %b want 1", b_req_ready); else n_pass++;
        n_checks++; if (b_rsp_valid !== 1'b0) $display("FAIL rst_b_rsp_valid: got %b want 0", b_rsp_valid); else n_pass++;
    endtask

    task automatic test_store_load;
        logic [31:0] rd; logic err; int cyc;
        xact(0, 1'b1, 32'h10, F_W, 32'hDEADBEEF, rd, err, cyc);
        n_checks++; if (cyc !== 3) $display("FAIL sw_latency: got %0d want 3", cyc); else n_pass++;
        n_checks++; if ({err, rd} !== 33'd0) $display("FAIL sw_rsp: got err=%b rdata=%h want 0/0", err, rd); else n_pass++;
        xact(0, 1'b0, 32'h10, F_W, 32'h0, rd, err, cyc);
        n_checks++; if (cyc !== 3) $display("FAIL lw_latency: got %0d want 3", cyc); else n_pass++;
        n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_10: got %h want deadbeef", rd); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL lw_10_err: got %b want 0", err); else n_pass++;
    endtask

    task automatic test_load_ext;
        logic [31:0] rd; logic err; int cyc;
        xact(0, 1'b0, 32'h13, F_B, 32'h0, rd, err, cyc);
        n_checks++; if (rd !== 32'hFFFFFFDE) $display("FAIL lb_13: got %h want ffffffde", rd); else n_pass++;
        xact(0, 1'b0, 32'h13, F_BU, 32'h0, rd, err, cyc);
        n_checks++; if (rd !== 32'h000000DE) $display("FAIL lbu_13: got %h want 000000de", rd); else n_pass++;
        xact(0, 1'b0, 32'h10, F_H, 32'h0, rd, err, cyc);
        n_checks++; if (rd !== 32'hFFFFBEEF) $display("FAIL lh_10: got %h want ffffbeef", rd); else n_pass++;
        xact(0, 1'b1, 32'h11, F_B, 32'h00000055, rd, err, cyc);
        n_checks++; if ({err, rd} !== 33'd0) $display("FAIL sb_11_rsp: got err=%b rdata=%h want 0/0", err, rd); else n_pass++;
        xact(0, 1'b0, 32'h10, F_W, 32'h0, rd, err, cyc);
        n_checks++; if (rd !== 32'hDEAD55EF) $display("FAIL lw_after_sb: got %h want dead55ef", rd); else n_pass++;
        xact(0, 1'b0, 32'h12, F_HU, 32'h0, rd, err, cyc);
        n_checks++; if (rd !== 32'h0000DEAD) $display("FAIL lhu_12: got %h want 0000dead", rd); else n_pass++;
        xact(0, 1'b0, 32'h12, F_H, 32'h0, rd, err, cyc);
        n_checks++; if (rd !== 32'hFFFFDEAD) $display("FAIL lh_12: got %h want ffffdead", rd); else n_pass++;
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic err; int cyc;
        xact(0, 1'b0, 32'h12, F_W, 32'h0, rd, err, cyc);
        n_checks++; if ({err, rd} !== {1'b1, 32'd0}) $display("FAIL lw_12_mis: got err=%b rdata=%h want 1/0", err, rd); else n_pass++;
        xact(0, 1'b1, 32'h11, F_H, 32'h0000FFFF, rd, err, cyc);
        n_checks++; if ({err, rd} !== {1'b1, 32'd0}) $display("FAIL sh_11_mis: got err=%b rdata=%h want 1/0", err, rd); else n_pass++;
        xact(0, 1'b1, 32'h10, F_BU, 32'h000000AA, rd, err, cyc);
        n_checks++; if ({err, rd} !== {1'b1, 32'd0}) $display("FAIL sbu_illegal: got err=%b rdata=%h want 1/0", err, rd); else n_pass++;
        xact(0, 1'b0, 32'h10, F_W, 32'h0, rd, err, cyc);
        n_checks++; if ({err, rd} !== {1'b0, 32'hDEAD55EF}) $display("FAIL lw_unchanged: got err=%b rdata=%h want 0/dead55ef", err, rd); else n_pass++;
        xact(0, 1'b0, 32'h1000, F_W, 32'h0, rd, err, cyc);
        n_checks++; if ({err, rd} !== {1'b1, 32'd0}) $display("FAIL lw_1000_oor: got err=%b rdata=%h want 1/0", err, rd); else n_pass++;
        xact(0, 1'b0, 32'hFFC, F_W, 32'h0, rd, err, cyc);
        n_checks++; if (err !== 1'b0) $display("FAIL lw_ffc_inrange: got err=%b want 0", err); else n_pass++;
        xact(0, 1'b0, 32'h10, 3'b011, 32'h0, rd, err, cyc);
        n_checks++; if ({err, rd} !== {1'b1, 32'd0}) $display("FAIL f3_011: got err=%b rdata=%h want 1/0", err, rd); else n_pass++;
        xact(0, 1'b0, 32'h10, 3'b110, 32'h0, rd, err, cyc);
        n_checks++; if ({err, rd} !== {1'b1, 32'd0}) $display("FAIL f3_110: got err=%b rdata=%h want 1/0", err, rd); else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [31:0] rd; logic err; int cyc;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h10;
        a_req_funct3 = F_W; a_req_wdata = 32'h0; a_rsp_ready = 1'b0;
        @(negedge clk);
        a_req_valid = 1'b0;
        cyc = 1;
        while (a_rsp_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++; if (cyc !== 3) $display("FAIL bp_latency: got %0d want 3", cyc); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (a_rsp_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", k, a_rsp_valid); else n_pass++;
            n_checks++; if ({a_rsp_err, a_rsp_rdata} !== {1'b0, 32'hDEAD55EF}) $display("FAIL bp_data[%0d]: got err=%b rdata=%h want 0/dead55ef", k, a_rsp_err, a_rsp_rdata); else n_pass++;
            n_checks++; if (a_req_ready !== 1'b0) $display("FAIL bp_req_ready[%0d]: got %b want 0", k, a_req_ready); else n_pass++;
            // A store pulse that must be ignored while the response is pending
            if (k == 1) begin
                a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h10;
                a_req_funct3 = F_W; a_req_wdata = 32'h0;
            end
            if (k == 2) a_req_valid = 1'b0;
            @(negedge clk);
        end
        a_rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({a_rsp_valid, a_req_ready} !== 2'b01) $display("FAIL bp_release: got valid=%b ready=%b want 0/1", a_rsp_valid, a_req_ready); else n_pass++;
        xact(0, 1'b0, 32'h10, F_W, 32'h0, rd, err, cyc);
        n_checks++; if (rd !== 32'hDEAD55EF) $display("FAIL bp_no_accept: got %h want dead55ef", rd); else n_pass++;
    endtask

    task automatic test_reset_wait;
        logic [31:0] rd; logic err; int cyc;
        bit seen;
        xact(0, 1'b1, 32'h20, F_W, 32'h11112222, rd, err, cyc);
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h20;
        a_req_funct3 = F_W; a_req_wdata = 32'h12345678; a_rsp_ready = 1'b1;
        @(negedge clk);
        a_req_valid = 1'b0;
        @(negedge clk);
        // Reset on the edge that would have moved WAIT->RESP
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (a_rsp_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL rw_no_rsp: got rsp_valid seen=%b want 0", seen); else n_pass++;
        xact(0, 1'b0, 32'h20, F_W, 32'h0, rd, err, cyc);
        n_checks++; if (rd !== 32'h11112222) $display("FAIL rw_mem_kept: got %h want 11112222", rd); else n_pass++;
    endtask

    task automatic test_reset_resp;
        logic [31:0] rd; logic err; int cyc;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h24;
        a_req_funct3 = F_W; a_req_wdata = 32'hA5A5A5A5; a_rsp_ready = 1'b0;
        @(negedge clk);
        a_req_valid = 1'b0;
        cyc = 1;
        while (a_rsp_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++; if (a_rsp_valid !== 1'b1) $display("FAIL rr_reach_resp: got %b want 1", a_rsp_valid); else n_pass++;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if ({a_rsp_valid, a_req_ready} !== 2'b01) $display("FAIL rr_dropped: got valid=%b ready=%b want 0/1", a_rsp_valid, a_req_ready); else n_pass++;
        a_rsp_ready = 1'b1;
        xact(0, 1'b0, 32'h24, F_W, 32'h0, rd, err, cyc);
        n_checks++; if (rd !== 32'hA5A5A5A5) $display("FAIL rr_committed: got %h want a5a5a5a5", rd); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; logic err; int cyc;
        int nrsp;
        xact(1, 1'b1, 32'h40, F_W, 32'hCAFEF00D, rd, err, cyc);
        n_checks++; if (cyc !== 1) $display("FAIL b2b_sw_latency: got %0d want 1", cyc); else n_pass++;
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'h40;
        b_req_funct3 = F_W; b_req_wdata = 32'h0; b_rsp_ready = 1'b1;
        nrsp = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_checks++; if (b_rsp_valid !== k[0]) $display("FAIL b2b_valid[%0d]: got %b want %b", k, b_rsp_valid, k[0]); else n_pass++;
            if (b_rsp_valid === 1'b1) begin
                nrsp++;
                n_checks++; if (b_rsp_rdata !== 32'hCAFEF00D) $display("FAIL b2b_rdata[%0d]: got %h want cafef00d", k, b_rsp_rdata); else n_pass++;
            end
        end
        b_req_valid = 1'b0;
        n_checks++; if (nrsp !== 4) $display("FAIL b2b_count: got %0d want 4", nrsp); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 32'h0;
        a_req_funct3 = 3'b0; a_req_wdata = 32'h0; a_rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'h0;
        b_req_funct3 = 3'b0; b_req_wdata = 32'h0; b_rsp_ready = 1'b1;
        test_reset();
        test_store_load();
        test_load_ext();
        test_errors();
        test_backpressure();
        test_reset_wait();
        test_reset_resp();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The module SHALL have a parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words of storage.
REQ-002 The module SHALL have a parameter LATENCY, default 2, giving the number of wait cycles between request accept and response; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 req_valid  input  1  core presents a load/store request.
REQ-006 req_ready  output  1  responder accepts a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_funct3  input  3  RV32I size code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 rsp_valid  output  1  response is available.
REQ-012 rsp_ready  input  1  core accepts the response.
REQ-013 rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 rsp_err  output  1  request was misaligned, out of range, or used an illegal funct3.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; no request is accepted in WAIT or RESP.
REQ-017 A request is accepted when req_valid=1 and req_ready=1; the module SHALL then register we, addr, funct3 and wdata.
REQ-018 On accept, the FSM SHALL go IDLE->WAIT with a counter loaded to LATENCY-1 when LATENCY>0, and IDLE->RESP directly when LATENCY=0.
REQ-019 In WAIT the counter SHALL decrement each cycle; at count 0 the FSM SHALL move to RESP, giving exactly LATENCY cycles in WAIT.
REQ-020 The memory access SHALL occur on the WAIT->RESP (or IDLE->RESP) edge, with rsp_rdata and rsp_err registered on that edge.
REQ-021 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1.
REQ-022 On the RESP cycle with rsp_ready=1, the FSM SHALL return to IDLE, so the minimum request-to-request spacing is LATENCY+2 cycles.
REQ-023 Storage SHALL be little-endian, word index addr[log2(DEPTH_WORDS)+1:2], byte lane addr[1:0].
REQ-024 Loads SHALL extend as follows: b/h sign-extend from bit 7/15; bu/hu zero-extend; w returns the full word.
REQ-025 Stores SHALL write only the addressed lanes: sb one lane, sh two lanes, sw all four; other bytes are unchanged.
REQ-026 Alignment rule: h/hu/sh need addr[0]=0 and w/sw need addr[1:0]=00; a violation SHALL set rsp_err=1, rsp_rdata=0 and leave memory unmodified.
REQ-027 addr >= 4*DEPTH_WORDS SHALL be an error handled as in REQ-026.
REQ-028 funct3 values 011, 110, 111, and 100/101 with we=1, SHALL be errors handled as in REQ-026.
REQ-029 A successful store SHALL respond with rsp_rdata=0 and rsp_err=0.
REQ-030 A load to the address of a store that has completed SHALL return the new data.
REQ-031 The response datapath SHALL not depend combinationally on req_* inputs.

Reset
REQ-032 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE with rsp_valid=0, rsp_rdata=0, rsp_err=0 and counter=0; req_ready is 1 after reset.
REQ-033 A reset during WAIT SHALL abort the request, and an aborted store SHALL not modify memory.
REQ-034 A reset during RESP SHALL drop the response, while a store already committed stays committed.
REQ-035 Memory contents SHALL not be cleared by reset.

Verification
REQ-036 LATENCY=2: sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> rsp_valid high exactly 3 cycles after each accept; load rdata 0xDEADBEEF, err 0.
REQ-037 After REQ-036: lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x10 -> 0xFFFFBEEF; sb 0x11 data 0x55 then lw 0x10 -> 0xDEAD55EF.
REQ-038 lw 0x12 and sh 0x11 -> rsp_err=1, rdata 0; a following lw 0x10 shows memory unchanged; lw 0x1000 with DEPTH_WORDS=1024 -> err 1.
REQ-039 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stable, req_ready=0 throughout, and a req_valid pulse is not accepted.
REQ-040 LATENCY=0: back-to-back loads with rsp_ready tied 1 -> one response every 2 cycles.
REQ-041 Reset in WAIT of sw 0x20 data 0x12345678 -> rsp_valid never asserts, and a later lw 0x20 returns the prior value.
